buzzer_sequencer: RTL and testbench
===================================

// Module: buzzer_sequencer
// PURPOSE
//   Plays a programmable note sequence on the square-wave buzzer generator. Holds a table of
//   (frequency, duration) entries and steps through them with millisecond timing. Drives the
//   generator's freq input and holds the generator in reset (mute) while silent.
//   Sits between the control FSM/host and the square-wave generator.
// PARAMETERS
//   CLK_FREQ  50000000  clock frequency in Hz; TICKS = CLK_FREQ/1000 cycles per ms (TICKS>=1)
//   DEPTH     16        note table entries
//   ADDR_W    4         table address width, 2**ADDR_W >= DEPTH
//   DUR_W     16        note duration width, units of ms
//   GAP_MS    10        silent gap between consecutive notes in ms; 0 = no gap
// PORTS
//   clk       in   1          clock
//   rst       in   1          synchronous, active-high reset
//   wr_en     in   1          table write strobe
//   wr_addr   in   ADDR_W     table write address; addr >= DEPTH ignored
//   wr_freq   in   16         note frequency in Hz; 0 = rest
//   wr_dur    in   DUR_W      note duration in ms; 0 treated as 1
//   seq_len   in   ADDR_W+1   notes to play, sampled at start; clamped to DEPTH
//   start     in   1          begin playback (level sampled each cycle)
//   stop      in   1          abort playback
//   freq      out  32         to generator freq; zero-extended wr_freq of current note
//   mute      out  1          to generator rst; 1 whenever no tone is sounding
//   busy      out  1          1 in PLAY or GAP
//   note_idx  out  ADDR_W     index of the current note
//   done      out  1          1-cycle pulse at normal end of sequence
// BEHAVIOUR
//   - Reset: state IDLE, freq=0, mute=1, busy=0, note_idx=0, done=0. Table entries cleared to 0.
//   - Table: register array, written on any clk edge with wr_en=1, including during playback.
//     Entries are read combinationally when a note is entered, so writes to later notes take effect.
//   - States: IDLE, PLAY, GAP. All outputs are registered.
//   - IDLE -> PLAY on the edge sampling start=1 and seq_len!=0: idx=0, freq=table[0].freq,
//     mute=(table[0].freq==0), busy=1. Tone is visible the cycle after start.
//     seq_len=0 is ignored: stays IDLE, no done.
//   - PLAY holds for exactly max(dur,1)*TICKS cycles, using a cycle counter cleared on note entry.
//   - At PLAY end, last note (idx==len-1): go to IDLE, freq=0, mute=1, busy=0, done=1 for one cycle.
//     No trailing gap.
//   - At PLAY end, not last note, GAP_MS>0: go to GAP for GAP_MS*TICKS cycles, freq=0, mute=1.
//     Then go to PLAY with idx+1.
//   - At PLAY end, not last note, GAP_MS=0: go directly to PLAY with idx+1 on the same edge.
//   - stop=1 in any state: IDLE on the next edge, freq=0, mute=1, busy=0, note_idx=0, no done.
//     If stop and start are both 1, stop wins.
//   - start while busy is ignored. seq_len is latched only at start.
//   - rst mid-sequence behaves as reset: playback aborted, no done.
//   - Counters sized for DUR_W-bit ms times TICKS, with no overflow at max duration.
// CONFIGURATION
//   BUZZER_SEQ_LOOP_EN defined: adds input port loop (1 bit), sampled at start.
//     If loop=1, at the end of the last note the sequencer enters GAP (if GAP_MS>0) and wraps to
//     idx=0 instead of finishing. done never pulses; only stop or rst ends playback.
//   BUZZER_SEQ_LOOP_EN undefined: the loop port does not exist; the sequence always ends with done.
// TESTING  (CLK_FREQ=4000 -> TICKS=4, GAP_MS=1, DEPTH=16)
//   1. Write {440,2} at idx 0, {880,1} at idx 1; seq_len=2, start pulse ->
//      freq=440, mute=0 for 8 cycles; freq=0, mute=1 for 4 cycles; freq=880 for 4 cycles;
//      then done=1 for 1 cycle, busy=0, freq=0.
//   2. Entry {0,3} (rest) at idx 0, seq_len=1 -> mute=1, freq=0, busy=1 for 12 cycles, then done.
//   3. stop asserted 3 cycles into note 0 -> next cycle IDLE, freq=0, mute=1, note_idx=0, no done;
//      start+stop in the same cycle -> stays IDLE.
//   4. seq_len=0 start -> no state change, no done. seq_len=20 -> plays 16 notes; idx 15 last.
//      wr_dur=0 -> note lasts 4 cycles.
//   5. During note 0, overwrite idx 1 with {1000,1} -> note 1 plays freq=1000.
//      start pulse while busy -> ignored.
//   6. BUZZER_SEQ_LOOP_EN, loop=1, seq_len=2 -> after idx 1 a 4-cycle gap, then idx 0 again,
//      no done; rst mid-note -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/buzzer_sequencer.sv
// Note-table sequencer driving the square-wave buzzer generator.
// Define BUZZER_SEQ_LOOP_EN to add the loop input (wrap instead of finish).
module buzzer_sequencer #(
    parameter int CLK_FREQ = 50000000,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int DUR_W    = 16,
    parameter int GAP_MS   = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_freq,
    input  logic [DUR_W-1:0]  wr_dur,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              start,
    input  logic              stop,
`ifdef BUZZER_SEQ_LOOP_EN
    input  logic              loop,
`endif
    output logic [31:0]       freq,
    output logic              mute,
    output logic              busy,
    output logic [ADDR_W-1:0] note_idx,
    output logic              done
);

    localparam int     TICKS = CLK_FREQ / 1000;
    localparam longint GAP_T = longint'(GAP_MS) * longint'(TICKS);
    localparam int     TW    = $clog2(TICKS + 1);
    localparam int     GW    = $clog2(GAP_T + 1);
    localparam int     CNT_W = (DUR_W + TW > GW) ? DUR_W + TW : GW;
    localparam logic [CNT_W-1:0] GAP_END =
        (GAP_T > 0) ? CNT_W'(GAP_T - 1) : '0;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t            state, state_nx;
    logic [15:0]       tbl_freq [DEPTH];
    logic [DUR_W-1:0]  tbl_dur  [DEPTH];
    logic [ADDR_W-1:0] idx, idx_nx, idx_adv;
    logic [ADDR_W:0]   len, len_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_end, end_nx;
    logic              loop_q, loop_nx, loop_in;
    logic              enter, fin, last, cnt_hit;
    logic [31:0]       freq_nx;
    logic              mute_nx, busy_nx, done_nx;
    logic [15:0]       ent_freq;
    logic [DUR_W-1:0]  ent_dur, dur_eff;

`ifdef BUZZER_SEQ_LOOP_EN
    assign loop_in = loop;
`else
    assign loop_in = 1'b0;
`endif

    assign last     = ({1'b0, idx} == len - 1'b1);
    assign cnt_hit  = (cnt == cnt_end);
    assign idx_adv  = last ? '0 : idx + 1'b1;
    assign note_idx = idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            len     <= '0;
            loop_q  <= 1'b0;
            cnt     <= '0;
            cnt_end <= '0;
            freq    <= '0;
            mute    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_freq[i] <= '0;
                tbl_dur[i]  <= '0;
            end
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            len     <= len_nx;
            loop_q  <= loop_nx;
            cnt     <= cnt_nx;
            cnt_end <= end_nx;
            freq    <= freq_nx;
            mute    <= mute_nx;
            busy    <= busy_nx;
            done    <= done_nx;
            if (wr_en && ({1'b0, wr_addr} < DEPTH_L)) begin
                tbl_freq[wr_addr] <= wr_freq;
                tbl_dur[wr_addr]  <= wr_dur;
            end
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        len_nx   = len;
        loop_nx  = loop_q;
        cnt_nx   = cnt + 1'b1;
        enter    = 1'b0;
        fin      = 1'b0;
        if (stop) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_nx = '0;
                    if (start && seq_len != '0) begin
                        state_nx = PLAY;
                        idx_nx   = '0;
                        len_nx   = (seq_len > DEPTH_L) ? DEPTH_L : seq_len;
                        loop_nx  = loop_in;
                        enter    = 1'b1;
                    end
                end
                PLAY: begin
                    if (cnt_hit) begin
                        cnt_nx = '0;
                        if (last && !loop_q) begin
                            state_nx = IDLE;
                            idx_nx   = '0;
                            fin      = 1'b1;
                        end else if (GAP_T > 0) begin
                            state_nx = GAP;
                        end else begin
                            idx_nx = idx_adv;
                            enter  = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt_hit) begin
                        state_nx = PLAY;
                        idx_nx   = idx_adv;
                        cnt_nx   = '0;
                        enter    = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Entering a note fetches the table row live, so late writes still land.
    always_comb begin
        ent_freq = tbl_freq[idx_nx];
        ent_dur  = tbl_dur[idx_nx];
        dur_eff  = (ent_dur == '0) ? DUR_W'(1) : ent_dur;
        freq_nx  = freq;
        mute_nx  = mute;
        end_nx   = cnt_end;
        busy_nx  = (state_nx != IDLE);
        done_nx  = fin;
        if (enter) begin
            freq_nx = {16'b0, ent_freq};
            mute_nx = (ent_freq == 16'd0);
            end_nx  = CNT_W'(dur_eff) * CNT_W'(TICKS) - 1'b1;
        end else if (state_nx != PLAY) begin
            freq_nx = '0;
            mute_nx = 1'b1;
            if (state_nx == GAP) end_nx = GAP_END;
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Bench for buzzer_sequencer: vector table, directed corners, random sequences
// checked against a per-cycle trace built from the note table.
module tb_buzzer_sequencer;

    localparam int TICKS = 4;
    localparam int GAP_T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_freq = '0;
    logic [15:0] wr_dur = '0;
    logic [4:0]  seq_len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
`ifdef BUZZER_SEQ_LOOP_EN
    logic        loop = 1'b0;
`endif
    logic [31:0] freq;
    logic        mute, busy, done;
    logic [3:0]  note_idx;

    buzzer_sequencer #(
        .CLK_FREQ(4000), .DEPTH(16), .ADDR_W(4), .DUR_W(16), .GAP_MS(1)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_freq(wr_freq), .wr_dur(wr_dur), .seq_len(seq_len),
        .start(start), .stop(stop),
`ifdef BUZZER_SEQ_LOOP_EN
        .loop(loop),
`endif
        .freq(freq), .mute(mute), .busy(busy),
        .note_idx(note_idx), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int f; bit m; bit b; bit d; int i; bit ci;
    } exp_t;

    typedef struct {
        bit st; bit sp; logic [4:0] len; int reps;
        int f; bit m; bit b; bit d; int i; bit ci;
    } vec_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   m_freq [16];
    int   m_dur  [16];
    exp_t exp_q [$];
    vec_t vt [13];
    int   pend_addr, pend_f, pend_d;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int ef, bit em, bit eb, bit ed,
                         int ei, bit ci);
        vectors++;
        if (freq !== 32'(ef) || mute !== em || busy !== eb ||
            done !== ed || (ci && note_idx !== 4'(ei))) begin
            miscompares++;
            $display("FAIL %s t=%0t: got freq=%0d mute=%0b busy=%0b done=%0b idx=%0d; want freq=%0d mute=%0b busy=%0b done=%0b idx=%0d%s",
                     name, $time, freq, mute, busy, done, note_idx,
                     ef, em, eb, ed, ei, ci ? "" : "(any)");
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 16; k++) begin
            m_freq[k] = 0;
            m_dur[k]  = 0;
        end
    endtask

    task automatic wr(int a, int f, int d);
        wr_en = 1'b1; wr_addr = 4'(a);
        wr_freq = 16'(f); wr_dur = 16'(d);
        step();
        wr_en = 1'b0;
        m_freq[a] = f;
        m_dur[a]  = d;
    endtask

    // Expected per-cycle outputs of one run, from the note table alone.
    function automatic void build(int len);
        int n;
        n = (len > 16) ? 16 : len;
        exp_q.delete();
        if (n == 0) begin
            repeat (3) exp_q.push_back('{0, 1, 0, 0, 0, 1});
            return;
        end
        for (int k = 0; k < n; k++) begin
            repeat (((m_dur[k] == 0) ? 1 : m_dur[k]) * TICKS)
                exp_q.push_back('{m_freq[k], m_freq[k] == 0, 1, 0, k, 1});
            if (k < n - 1)
                repeat (GAP_T) exp_q.push_back('{0, 1, 1, 0, 0, 0});
        end
        exp_q.push_back('{0, 1, 0, 1, 0, 0});
        repeat (2) exp_q.push_back('{0, 1, 0, 0, 0, 0});
    endfunction

    task automatic run_seq(string name, int len, bit inj);
        build(len);
        seq_len = 5'(len);
        start = 1'b1;
        foreach (exp_q[k]) begin
            step();
            if (k == 0) start = 1'b0;
            if (inj && k == 1) begin
                wr_en = 1'b1; wr_addr = 4'(pend_addr);
                wr_freq = 16'(pend_f); wr_dur = 16'(pend_d);
                start = 1'b1;
            end
            if (inj && k == 2) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
            check(name, exp_q[k].f, exp_q[k].m, exp_q[k].b,
                  exp_q[k].d, exp_q[k].i, exp_q[k].ci);
        end
    endtask

    initial begin
        clear_model();
        step();
        step();
        check("reset", 0, 1, 0, 0, 0, 1);
        rst = 1'b0;
        run_seq("cleared_tbl", 1, 0);

        wr(0, 440, 2);
        wr(1, 880, 1);
        vt[0]  = '{1, 0, 2, 1, 440, 0, 1, 0, 0, 1};
        vt[1]  = '{0, 0, 2, 7, 440, 0, 1, 0, 0, 1};
        vt[2]  = '{0, 0, 2, 4, 0, 1, 1, 0, 0, 0};
        vt[3]  = '{0, 0, 2, 4, 880, 0, 1, 0, 1, 1};
        vt[4]  = '{0, 0, 2, 1, 0, 1, 0, 1, 0, 0};
        vt[5]  = '{0, 0, 2, 2, 0, 1, 0, 0, 0, 0};
        vt[6]  = '{1, 0, 2, 1, 440, 0, 1, 0, 0, 1};
        vt[7]  = '{0, 0, 2, 2, 440, 0, 1, 0, 0, 1};
        vt[8]  = '{0, 1, 2, 1, 0, 1, 0, 0, 0, 1};
        vt[9]  = '{0, 0, 2, 12, 0, 1, 0, 0, 0, 1};
        vt[10] = '{1, 1, 2, 2, 0, 1, 0, 0, 0, 1};
        vt[11] = '{1, 0, 0, 3, 0, 1, 0, 0, 0, 1};
        vt[12] = '{0, 0, 0, 2, 0, 1, 0, 0, 0, 1};
        for (int v = 0; v < 13; v++) begin
            start = vt[v].st; stop = vt[v].sp; seq_len = vt[v].len;
            for (int r = 0; r < vt[v].reps; r++) begin
                step();
                check($sformatf("vec%0d", v), vt[v].f, vt[v].m,
                      vt[v].b, vt[v].d, vt[v].i, vt[v].ci);
            end
        end
        start = 1'b0; stop = 1'b0;

        wr(0, 0, 3);
        run_seq("rest", 1, 0);

        for (int k = 0; k < 16; k++) wr(k, 100 + k * 50, k % 3);
        run_seq("len20", 20, 0);

        wr(0, 500, 1);
        wr(1, 700, 2);
        pend_addr = 1; pend_f = 1000; pend_d = 1;
        m_freq[1] = 1000; m_dur[1] = 1;
        run_seq("overwrite", 2, 1);

`ifdef BUZZER_SEQ_LOOP_EN
        wr(0, 440, 2);
        wr(1, 880, 1);
        loop = 1'b1; seq_len = 5'd2; start = 1'b1;
        step();
        start = 1'b0;
        check("loop", 440, 0, 1, 0, 0, 1);
        for (int p = 0; p < 2; p++) begin
            for (int c = (p == 0) ? 1 : 0; c < 8; c++) begin
                check("loop_n0", 440, 0, 1, 0, 0, 1);
                if (c < 7) step();
            end
            repeat (GAP_T) begin step(); check("loop_gap", 0, 1, 1, 0, 0, 0); end
            repeat (4) begin step(); check("loop_n1", 880, 0, 1, 0, 1, 1); end
            repeat (GAP_T) begin step(); check("loop_gap", 0, 1, 1, 0, 0, 0); end
            step();
        end
        check("loop_wrap", 440, 0, 1, 0, 0, 1);
        loop = 1'b0; stop = 1'b1;
        step();
        stop = 1'b0;
        check("loop_stop", 0, 1, 0, 0, 0, 1);
`endif

        wr(0, 300, 5);
        seq_len = 5'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("pre_rst", 300, 0, 1, 0, 0, 1);
        rst = 1'b1;
        step();
        check("rst_mid", 0, 1, 0, 0, 0, 1);
        rst = 1'b0;
        clear_model();
        repeat (3) begin step(); check("rst_nodone", 0, 1, 0, 0, 0, 1); end
        run_seq("post_rst", 1, 0);

        for (int it = 0; it < 8; it++) begin
            repeat (5) begin
                int a, f, d;
                a = int'($urandom_range(0, 15));
                f = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 5000));
                d = int'($urandom_range(0, 3));
                wr(a, f, d);
            end
            run_seq($sformatf("rand%0d", it), int'($urandom_range(0, 20)), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
